// File: rtl/aer_event_encoder_if.sv
// ---------------------------------------------------------------------------------------------
// aer_event_encoder_if
//   Bundles the two handshakes that surround the event encoder:
//     - grant side: one-hot group/pixel grants from the arbitration tree, a live-event strobe,
//       and the arb_enable throttle sent back to the arbiters;
//     - event stream: valid/ready output carrying the binary {group, pixel} address and the
//       capture timestamp.
//   modport master : the encoder (consumes grants, drives arb_enable and the event stream)
//   modport slave  : the environment (arbiters + downstream sink)
// ---------------------------------------------------------------------------------------------
interface aer_event_encoder_if #(
    parameter int unsigned GRP_N = 16,
    parameter int unsigned PXL_N = 16,
    parameter int unsigned TS_W  = 16
);
    localparam int unsigned AW = $clog2(GRP_N) + $clog2(PXL_N);

    logic [GRP_N-1:0] grp_gnt;
    logic [PXL_N-1:0] pxl_gnt;
    logic             gnt_valid;
    logic             arb_enable;
    logic             ev_valid;
    logic             ev_ready;
    logic [AW-1:0]    ev_addr;
    logic [TS_W-1:0]  ev_ts;

    modport master (
        input  grp_gnt, pxl_gnt, gnt_valid, ev_ready,
        output arb_enable, ev_valid, ev_addr, ev_ts
    );

    modport slave (
        output grp_gnt, pxl_gnt, gnt_valid, ev_ready,
        input  arb_enable, ev_valid, ev_addr, ev_ts
    );
endinterface

// File: rtl/aer_event_encoder.sv
// ---------------------------------------------------------------------------------------------
// aer_event_encoder
//   Consumer end of a two-level pixel arbitration tree. Each live grant pair (one-hot group,
//   one-hot pixel) is encoded to a binary {group, pixel} address, stamped with a free-running
//   timestamp and buffered in a show-ahead FIFO drained over a valid/ready stream. arb_enable
//   throttles the arbiters when the FIFO nears full; a flush request drains the FIFO and
//   returns to idle with a one-cycle flush_done pulse.
// Ports
//   clk, rst_n   : clock, asynchronous reset (active HIGH despite the name)
//   start        : pulse, idle -> run
//   flush_req    : pulse, run -> drain
//   clr_err      : clears overflow / onehot_err (a same-cycle set wins)
//   ev_if        : grant handshake + event stream (master modport)
//   fifo_level   : registered FIFO occupancy, 0..FIFO_DEPTH
//   flush_done   : pulse when a drain completes
//   overflow     : sticky, grant offered while arb_enable was low
//   onehot_err   : sticky, accepted grant pair not exactly one-hot
// ---------------------------------------------------------------------------------------------
module aer_event_encoder #(
    parameter int unsigned GRP_N      = 16,
    parameter int unsigned PXL_N      = 16,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AFULL_LVL  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          flush_req,
    input  logic                          clr_err,
    aer_event_encoder_if.master           ev_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          flush_done,
    output logic                          overflow,
    output logic                          onehot_err
);
    localparam int unsigned GA_W    = $clog2(GRP_N);
    localparam int unsigned PA_W    = $clog2(PXL_N);
    localparam int unsigned AW      = GA_W + PA_W;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = AW + TS_W;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    function automatic logic [GA_W-1:0] grp_index(input logic [GRP_N-1:0] v);
        logic [GA_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < GRP_N; i++) begin
            if (v[i]) idx = idx | GA_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [PA_W-1:0] pxl_index(input logic [PXL_N-1:0] v);
        logic [PA_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < PXL_N; i++) begin
            if (v[i]) idx = idx | PA_W'(i);
        end
        return idx;
    endfunction

    state_e                         state_q, state_d;
    logic [TS_W-1:0]                ts_q, ts_d;
    logic [LVL_W-1:0]               level_q, level_d;
    logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]             mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]             mem_d [FIFO_DEPTH];
    logic                           arb_enable_q, arb_enable_d;
    logic                           flush_done_q, flush_done_d;
    logic                           overflow_q, overflow_d;
    logic                           onehot_err_q, onehot_err_d;

    logic                           grp_ok, pxl_ok;
    logic                           gnt_live, push, pop, ev_valid;
    logic [ENTRY_W-1:0]             head;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign grp_ok = (ev_if.grp_gnt != '0) &&
                    ((ev_if.grp_gnt & (ev_if.grp_gnt - 1'b1)) == '0);
    assign pxl_ok = (ev_if.pxl_gnt != '0) &&
                    ((ev_if.pxl_gnt & (ev_if.pxl_gnt - 1'b1)) == '0);

    assign ev_valid = (level_q != '0);
    assign gnt_live = ev_if.gnt_valid && arb_enable_q && (state_q == StRun);
    assign push     = gnt_live && grp_ok && pxl_ok;
    assign pop      = ev_valid && ev_if.ev_ready;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (flush_req) state_d = StDrain;
            StDrain: begin
                if (level_q == '0) begin
                    state_d      = StIdle;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        if (push) mem_d[wr_ptr_q] = {grp_index(ev_if.grp_gnt), pxl_index(ev_if.pxl_gnt), ts_q};

        // Counter is parked at zero in idle, including the cycle that enters run.
        ts_d = ((state_q != StIdle) && (state_d != StIdle)) ? ts_q + 1'b1 : '0;

        // Registered throttle: one cycle of lag is absorbed by AFULL_LVL >= 1 spare entries.
        arb_enable_d = (state_d == StRun) &&
                       ((LVL_W'(FIFO_DEPTH) - level_d) > LVL_W'(AFULL_LVL));

        overflow_d   = (ev_if.gnt_valid && !arb_enable_q) || (overflow_q && !clr_err);
        onehot_err_d = (gnt_live && !(grp_ok && pxl_ok)) || (onehot_err_q && !clr_err);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= StIdle;
            ts_q         <= '0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            arb_enable_q <= 1'b0;
            flush_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            onehot_err_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            level_q      <= level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            arb_enable_q <= arb_enable_d;
            flush_done_q <= flush_done_d;
            overflow_q   <= overflow_d;
            onehot_err_q <= onehot_err_d;
            mem_q        <= mem_d;
        end
    end

    // Address/timestamp forced to zero when empty so reset clears them immediately.
    assign {ev_if.ev_addr, ev_if.ev_ts} = ev_valid ? head : '0;
    assign ev_if.ev_valid   = ev_valid;
    assign ev_if.arb_enable = arb_enable_q;
    assign fifo_level       = level_q;
    assign flush_done       = flush_done_q;
    assign overflow         = overflow_q;
    assign onehot_err       = onehot_err_q;
endmodule

// File: tb/tb_aer_event_encoder.sv
module tb_aer_event_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       flush_req = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] fifo_level;
    logic       flush_done, overflow, onehot_err;

    aer_event_encoder_if #(.GRP_N(16), .PXL_N(16), .TS_W(16)) bus ();

    aer_event_encoder #(
        .GRP_N(16), .PXL_N(16), .TS_W(16), .FIFO_DEPTH(8), .AFULL_LVL(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .flush_req  (flush_req),
        .clr_err    (clr_err),
        .ev_if      (bus),
        .fifo_level (fifo_level),
        .flush_done (flush_done),
        .overflow   (overflow),
        .onehot_err (onehot_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model: event queue + counters ----------------
    typedef struct {
        logic [7:0]  addr;
        logic [15:0] ts;
    } ev_t;

    ev_t mq[$];
    int  m_phase;  // 0 idle, 1 run, 2 drain
    int  m_ts;
    bit  m_arb, m_ovf, m_ohe, m_fd;

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_ts    = 0;
        m_arb   = 0;
        m_ovf   = 0;
        m_ohe   = 0;
        m_fd    = 0;
    endtask

    function automatic int onehot_pos(input logic [15:0] v);
        int cnt, pos;
        cnt = 0;
        pos = -1;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                cnt++;
                pos = i;
            end
        end
        return (cnt == 1) ? pos : -1;
    endfunction

    task automatic model_step();
        int size_now, nxt, gp, pp;
        bit ovf_n, ohe_n;
        ev_t e;
        size_now = mq.size();
        nxt      = m_phase;
        ovf_n    = m_ovf && !clr_err;
        ohe_n    = m_ohe && !clr_err;
        if (bus.gnt_valid && !m_arb) ovf_n = 1;
        if (size_now > 0 && bus.ev_ready) void'(mq.pop_front());
        if (bus.gnt_valid && m_arb) begin
            gp = onehot_pos(bus.grp_gnt);
            pp = onehot_pos(bus.pxl_gnt);
            if (gp >= 0 && pp >= 0) begin
                e.addr = 8'(gp * 16 + pp);
                e.ts   = 16'(m_ts);
                mq.push_back(e);
            end else begin
                ohe_n = 1;
            end
        end
        m_fd = (m_phase == 2) && (size_now == 0);
        case (m_phase)
            0: if (start) nxt = 1;
            1: if (flush_req) nxt = 2;
            default: if (size_now == 0) nxt = 0;
        endcase
        m_ts    = (m_phase != 0 && nxt != 0) ? (m_ts + 1) % 65536 : 0;
        m_phase = nxt;
        m_arb   = (nxt == 1) && (8 - mq.size() > 2);
        m_ovf   = ovf_n;
        m_ohe   = ohe_n;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic        ev;
        logic [7:0]  ea;
        logic [15:0] et;
        logic [63:0] act, exp;
        ev  = (mq.size() > 0);
        ea  = ev ? mq[0].addr : 8'h0;
        et  = ev ? mq[0].ts : 16'h0;
        act = {31'b0, bus.ev_valid, ev ? bus.ev_addr : 8'h0, ev ? bus.ev_ts : 16'h0,
               fifo_level, bus.arb_enable, overflow, onehot_err, flush_done};
        exp = {31'b0, ev, ea, et, 4'(mq.size()), m_arb, m_ovf, m_ohe, m_fd};
        check("model", act, exp);
    endtask

    // Inputs are set; compare current outputs to model, advance both one clock.
    task automatic tick();
        @(negedge clk);
        compare_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic gv, input logic [15:0] g,
                         input logic [15:0] p, input logic r, input logic c);
        start         = s;
        flush_req     = f;
        bus.gnt_valid = gv;
        bus.grp_gnt   = g;
        bus.pxl_gnt   = p;
        bus.ev_ready  = r;
        clr_err       = c;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    function automatic logic [15:0] rand_oh();
        return 16'h1 << $urandom_range(0, 15);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        s, f, gv;
        logic [15:0] g, p;
        logic        r, c;
        logic        v;
        logic [7:0]  addr;
        logic [15:0] ts;
        logic [3:0]  lvl;
        logic        arb, ovf, ohe;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int          max_lvl, fd_cnt;
        logic [63:0] act, exp;

        vecs[0]  = '{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 16'd0, 4'd0, 1, 0, 0};
        for (int i = 1; i <= 5; i++)
            vecs[i] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 16'd0, 4'd0, 1, 0, 0};
        vecs[6]  = '{0, 0, 1, 16'h0008, 16'h0400, 1, 0, 1, 8'h3A, 16'd5, 4'd1, 1, 0, 0};
        vecs[7]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 8'h00, 16'd0, 4'd0, 1, 0, 0};
        vecs[8]  = '{0, 0, 1, 16'h0008, 16'h0005, 1, 0, 0, 8'h00, 16'd0, 4'd0, 1, 0, 1};
        vecs[9]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 8'h00, 16'd0, 4'd0, 1, 0, 0};
        vecs[10] = '{0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, 8'h00, 16'd0, 4'd0, 1, 0, 1};
        vecs[11] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 8'h00, 16'd0, 4'd0, 1, 0, 0};
        vecs[12] = '{0, 0, 1, 16'h0101, 16'h0001, 1, 0, 0, 8'h00, 16'd0, 4'd0, 1, 0, 1};
        vecs[13] = '{0, 0, 1, 16'h0000, 16'h0010, 1, 1, 0, 8'h00, 16'd0, 4'd0, 1, 0, 1};
        vecs[14] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 8'h00, 16'd0, 4'd0, 1, 0, 0};

        // reset state
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_outputs",
              {bus.ev_valid, bus.ev_addr, bus.ev_ts, fifo_level, bus.arb_enable,
               overflow, onehot_err, flush_done}, 64'h0);
        rst_n = 1'b0;

        // table: first event encoding, one-hot error and clear priority
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].s, vecs[i].f, vecs[i].gv, vecs[i].g, vecs[i].p, vecs[i].r, vecs[i].c);
            tick();
            act = {bus.ev_valid, vecs[i].v ? bus.ev_addr : 8'h0, vecs[i].v ? bus.ev_ts : 16'h0,
                   fifo_level, bus.arb_enable, overflow, onehot_err};
            exp = {vecs[i].v, vecs[i].addr, vecs[i].ts, vecs[i].lvl, vecs[i].arb,
                   vecs[i].ovf, vecs[i].ohe};
            check($sformatf("vec%0d", i), act, exp);
        end

        // back-pressure: one event per cycle with the sink stalled
        max_lvl = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, rand_oh(), rand_oh(), 0, 0);
            tick();
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
        check("afull_max_level", 64'(max_lvl), 64'd6);
        check("afull_arb", {63'b0, bus.arb_enable}, 64'd0);
        check("afull_ovf", {63'b0, overflow}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 16'h0, 16'h0, 1, 0);
            tick();
        end
        check("afull_drained", {59'b0, fifo_level, bus.arb_enable}, {59'b0, 4'd0, 1'b1});
        drive(0, 0, 0, 16'h0, 16'h0, 0, 1);
        tick();
        check("clr_ovf", {63'b0, overflow}, 64'd0);

        // flush sequence
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, rand_oh(), rand_oh(), 0, 0);
            tick();
        end
        drive(0, 1, 0, 16'h0, 16'h0, 0, 0);
        tick();
        check("flush_arb", {63'b0, bus.arb_enable}, 64'd0);
        drive(0, 0, 1, rand_oh(), rand_oh(), 0, 0);
        tick();
        check("flush_ovf", {63'b0, overflow}, 64'd1);
        fd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 16'h0, 16'h0, 1, 0);
            tick();
            if (flush_done) fd_cnt++;
        end
        check("flush_done_cnt", 64'(fd_cnt), 64'd1);
        drive(1, 0, 0, 16'h0, 16'h0, 1, 0);
        tick();
        check("restart_arb", {63'b0, bus.arb_enable}, 64'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 6,
                  ($urandom_range(0, 99) < 85) ? rand_oh() : 16'($urandom),
                  ($urandom_range(0, 99) < 85) ? rand_oh() : 16'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
            tick();
        end

        // timestamp wrap
        do_reset();
        drive(1, 0, 0, 16'h0, 16'h0, 1, 0);
        tick();
        drive(0, 0, 0, 16'h0, 16'h0, 1, 0);
        while (m_ts != 65535) tick();
        drive(0, 0, 1, 16'h0002, 16'h0001, 1, 0);
        tick();
        drive(0, 0, 1, 16'h0004, 16'h0002, 1, 0);
        tick();
        check("ts_wrap", {48'b0, bus.ev_ts}, 64'd0);
        drive(0, 0, 1, 16'h0008, 16'h0004, 1, 0);
        tick();
        check("ts_after_wrap", {48'b0, bus.ev_ts}, 64'd1);
        drive(0, 0, 0, 16'h0, 16'h0, 1, 0);
        for (int i = 0; i < 4; i++) tick();

        // asynchronous reset with buffered events
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, rand_oh(), rand_oh(), 0, 0);
            tick();
        end
        check("prefill", {59'b0, fifo_level, bus.ev_valid}, {59'b0, 4'd5, 1'b1});
        #2 rst_n = 1'b1;
        #1;
        check("rst_async",
              {bus.ev_valid, bus.ev_addr, bus.ev_ts, fifo_level, bus.arb_enable,
               overflow, onehot_err, flush_done}, 64'h0);
        model_reset();
        drive(0, 0, 0, 16'h0, 16'h0, 1, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        drive(1, 0, 0, 16'h0, 16'h0, 1, 0);
        tick();
        drive(0, 0, 0, 16'h0, 16'h0, 1, 0);
        for (int i = 0; i < 10; i++) tick();
        check("no_stale", {63'b0, bus.ev_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
